// File: rtl/bp_pkg.sv
// Shared types for the branch resolve / predictor rollback slice: FSM encoding
// and the per-stage branch tracking record.
package bp_pkg;

    localparam int unsigned PC_W      = 32;
    localparam int unsigned BP_PC_INC = 4;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_REPAIR = 1'b1
    } bp_state_t;

    typedef struct packed {
        logic            is_br;
        logic            pred_taken;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred_target;
    } track_data_t;

    typedef struct packed {
        logic        valid;
        track_data_t data;
    } track_rec_t;

endpackage

// File: rtl/bp_track_stage.sv
// One pipeline tracking register for a fetched branch: advances when not stalled,
// and a flush drops the valid bit at the next edge even while stalled.
module bp_track_stage
    import bp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       flush,
    input  track_rec_t d,
    output track_rec_t q
);

    logic        vld_q;
    track_data_t data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (!stall) begin
            vld_q <= d.valid;
        end
    end

    // Payload is only meaningful behind vld_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!stall) begin
            data_q <= d.data;
        end
    end

    assign q.valid = vld_q;
    assign q.data  = data_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller: compares EX outcome against the tracked prediction,
// drives speculative history updates, rollback, fetch redirect and statistics.
module branch_resolve_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned PC_INC     = BP_PC_INC,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PL_stall,
    input  logic                  if_valid,
    input  logic                  if_is_branch,
    input  logic                  if_pred_taken,
    input  logic [PC_W-1:0]       pc,
    input  logic [PC_W-1:0]       if_pred_target,
    input  logic                  ex_actual_taken,
    input  logic [PC_W-1:0]       ex_actual_target,
    output logic                  corrected_en,
    output logic                  corrected_result,
    output logic                  rollback_en_id,
    output logic                  rollback_en_ex,
    output logic                  prediction_result_branch_failed,
    output logic                  redirect_en,
    output logic [PC_W-1:0]       redirect_pc,
    output logic                  flush,
    output logic [STAT_WIDTH-1:0] branch_cnt,
    output logic [STAT_WIDTH-1:0] mispredict_cnt
);

    function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    bp_state_t  state;
    logic       act_latched;
    track_rec_t if_p0;
    track_rec_t id_p1;
    track_rec_t ex_p2;
    logic       ex_retire;
    logic       dir_miss;
    logic       tgt_miss;
    logic       mispredict;

    always_comb begin
        if_p0.valid            = if_valid;
        if_p0.data.is_br       = if_is_branch;
        if_p0.data.pred_taken  = if_pred_taken;
        if_p0.data.pc          = pc;
        if_p0.data.pred_target = if_pred_target;
    end

    // IF -> ID boundary
    bp_track_stage u_id_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (PL_stall),
        .flush (flush),
        .d     (if_p0),
        .q     (id_p1)
    );

    // ID -> EX boundary
    bp_track_stage u_ex_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (PL_stall),
        .flush (flush),
        .d     (id_p1),
        .q     (ex_p2)
    );

    assign ex_retire  = ex_p2.valid & ex_p2.data.is_br & ~PL_stall & (state == ST_RUN);
    assign dir_miss   = ex_actual_taken != ex_p2.data.pred_taken;
    // A right direction with a wrong taken target still has to be repaired.
    assign tgt_miss   = ex_actual_taken & (ex_actual_target != ex_p2.data.pred_target);
    assign mispredict = ex_retire & (dir_miss | tgt_miss);

    always_comb begin
        corrected_en                    = 1'b0;
        corrected_result                = 1'b0;
        rollback_en_id                  = 1'b0;
        rollback_en_ex                  = 1'b0;
        prediction_result_branch_failed = 1'b0;
        redirect_en                     = 1'b0;
        redirect_pc                     = '0;
        flush                           = 1'b0;
        if (rst_n) begin
            if (state == ST_REPAIR) begin
                corrected_en     = 1'b1;
                corrected_result = act_latched;
            end else begin
                corrected_result = if_pred_taken;
                corrected_en     = if_valid & if_is_branch & ~PL_stall & ~mispredict;
                if (mispredict) begin
                    rollback_en_ex                  = 1'b1;
                    rollback_en_id                  = id_p1.valid & id_p1.data.is_br;
                    prediction_result_branch_failed = ex_p2.data.pred_taken;
                    redirect_en                     = 1'b1;
                    flush                           = 1'b1;
                    redirect_pc = ex_actual_taken ? ex_actual_target
                                                  : ex_p2.data.pc + PC_W'(PC_INC);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_RUN;
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else begin
            case (state)
                ST_RUN:    if (mispredict) state <= ST_REPAIR;
                ST_REPAIR: state <= ST_RUN;
                default:   state <= ST_RUN;
            endcase
            if (ex_retire) begin
                branch_cnt <= sat_inc(branch_cnt);
            end
            if (mispredict) begin
                mispredict_cnt <= sat_inc(mispredict_cnt);
            end
        end
        if (mispredict) begin
            act_latched <= ex_actual_taken;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a cycle-level reference model and
// literal spot checks on the documented scenarios.
module tb_branch_resolve_ctrl;

    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          PL_stall;
    logic          if_valid, if_is_branch, if_pred_taken;
    logic [31:0]   pc, if_pred_target;
    logic          ex_actual_taken;
    logic [31:0]   ex_actual_target;
    logic          corrected_en, corrected_result, rollback_en_id, rollback_en_ex;
    logic          prediction_result_branch_failed, redirect_en, flush;
    logic [31:0]   redirect_pc;
    logic [SW-1:0] branch_cnt, mispredict_cnt;

    int n_vec = 0;
    int n_mis = 0;

    branch_resolve_ctrl #(.PC_INC(4), .STAT_WIDTH(SW)) dut (
        .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall),
        .if_valid(if_valid), .if_is_branch(if_is_branch), .if_pred_taken(if_pred_taken),
        .pc(pc), .if_pred_target(if_pred_target),
        .ex_actual_taken(ex_actual_taken), .ex_actual_target(ex_actual_target),
        .corrected_en(corrected_en), .corrected_result(corrected_result),
        .rollback_en_id(rollback_en_id), .rollback_en_ex(rollback_en_ex),
        .prediction_result_branch_failed(prediction_result_branch_failed),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .flush(flush),
        .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a two-entry list of in-flight instructions (index 0 = ID,
    // 1 = EX), a pending-repair flag with the true outcome, and statistics.
    typedef struct {
        bit        v;
        bit        br;
        bit        pt;
        bit [31:0] pc;
        bit [31:0] tg;
    } slot_t;

    slot_t     m_pipe [2];
    bit        m_repair = 0;
    bit        m_truth  = 0;
    int        m_bcnt   = 0;
    int        m_mcnt   = 0;
    localparam int CMAX = (1 << SW) - 1;

    function automatic bit m_retires();
        return rst_n && !m_repair && !PL_stall && m_pipe[1].v && m_pipe[1].br;
    endfunction

    function automatic bit m_wrong();
        if (!m_retires()) return 0;
        if (ex_actual_taken != m_pipe[1].pt) return 1;
        return ex_actual_taken && (ex_actual_target != m_pipe[1].tg);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_pipe[0].v <= 0;
            m_pipe[1].v <= 0;
            m_repair    <= 0;
            m_bcnt      <= 0;
            m_mcnt      <= 0;
        end else begin
            if (m_retires()) m_bcnt <= (m_bcnt == CMAX) ? CMAX : m_bcnt + 1;
            if (m_wrong()) begin
                m_mcnt      <= (m_mcnt == CMAX) ? CMAX : m_mcnt + 1;
                m_truth     <= ex_actual_taken;
                m_pipe[0].v <= 0;
                m_pipe[1].v <= 0;
            end else if (!PL_stall) begin
                m_pipe[1] <= m_pipe[0];
                m_pipe[0] <= '{v: if_valid, br: if_is_branch, pt: if_pred_taken,
                               pc: pc, tg: if_pred_target};
            end
            m_repair <= m_wrong();
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_cycle();
        bit        e_cen = 0, e_cres = 0, e_rid = 0, e_rex = 0, e_fail = 0, e_redir = 0;
        bit [31:0] e_rpc = 0;
        bit        w;
        if (rst_n) begin
            if (m_repair) begin
                e_cen  = 1;
                e_cres = m_truth;
            end else begin
                w      = m_wrong();
                e_cres = if_pred_taken;
                e_cen  = if_valid && if_is_branch && !PL_stall && !w;
                if (w) begin
                    e_rex   = 1;
                    e_rid   = m_pipe[0].v && m_pipe[0].br;
                    e_fail  = m_pipe[1].pt;
                    e_redir = 1;
                    e_rpc   = ex_actual_taken ? ex_actual_target : m_pipe[1].pc + 32'd4;
                end
            end
        end
        chk("m.corrected_en", 32'(corrected_en), 32'(e_cen));
        chk("m.corrected_result", 32'(corrected_result), 32'(e_cres));
        chk("m.rollback_en_id", 32'(rollback_en_id), 32'(e_rid));
        chk("m.rollback_en_ex", 32'(rollback_en_ex), 32'(e_rex));
        chk("m.failed", 32'(prediction_result_branch_failed), 32'(e_fail));
        chk("m.redirect_en", 32'(redirect_en), 32'(e_redir));
        chk("m.flush", 32'(flush), 32'(e_redir));
        chk("m.redirect_pc", redirect_pc, e_rpc);
        chk("m.branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
        chk("m.mispredict_cnt", 32'(mispredict_cnt), 32'(m_mcnt));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input bit v, input bit br, input bit pt, input bit [31:0] p,
                         input bit [31:0] tg);
        if_valid = v; if_is_branch = br; if_pred_taken = pt; pc = p; if_pred_target = tg;
    endtask

    task automatic ex_res(input bit at, input bit [31:0] atg);
        ex_actual_taken = at; ex_actual_target = atg;
        #1;
    endtask

    initial begin
        rst_n = 0; PL_stall = 0;
        fetch(0, 0, 0, 0, 0);
        ex_actual_taken = 0; ex_actual_target = 0;
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none
        repeat (2) tick();
        chk("reset.branch_cnt", 32'(branch_cnt), 0);
        chk("reset.redirect_en", 32'(redirect_en), 0);
        rst_n = 1;

        // 1: correct not-taken branch
        fetch(1, 1, 0, 32'h100, 32'h200); #1;
        chk("t1.corrected_en", 32'(corrected_en), 1);
        tick(); fetch(0, 0, 0, 0, 0); tick();
        ex_res(0, 32'h0);
        chk("t1.redirect_en", 32'(redirect_en), 0);
        chk("t1.rollback_en_ex", 32'(rollback_en_ex), 0);
        tick();
        chk("t1.branch_cnt", 32'(branch_cnt), 1);
        chk("t1.mispredict_cnt", 32'(mispredict_cnt), 0);

        // 2: predicted taken, actually not taken
        fetch(1, 1, 1, 32'h100, 32'h200); tick(); fetch(0, 0, 0, 0, 0); tick();
        ex_res(0, 32'h0);
        chk("t2.rollback_en_ex", 32'(rollback_en_ex), 1);
        chk("t2.failed", 32'(prediction_result_branch_failed), 1);
        chk("t2.redirect_pc", redirect_pc, 32'h104);
        chk("t2.flush", 32'(flush), 1);
        tick();
        chk("t2.corrected_en", 32'(corrected_en), 1);
        chk("t2.corrected_result", 32'(corrected_result), 0);
        tick();
        chk("t2.mispredict_cnt", 32'(mispredict_cnt), 1);

        // 3: mispredict with a younger branch in ID and a branch in fetch
        fetch(1, 1, 1, 32'h100, 32'h200); tick();
        fetch(1, 1, 0, 32'h104, 32'h180); tick();
        fetch(1, 1, 1, 32'h108, 32'h300); ex_res(0, 32'h0);
        chk("t3.rollback_en_id", 32'(rollback_en_id), 1);
        chk("t3.fetch_suppressed", 32'(corrected_en), 0);
        tick(); fetch(0, 0, 0, 0, 0); tick();
        ex_res(1, 32'h999);
        chk("t3.ex_cleared", 32'(redirect_en), 0);
        tick(); tick();

        // 4: right direction, wrong target
        fetch(1, 1, 1, 32'h100, 32'h200); tick(); fetch(0, 0, 0, 0, 0); tick();
        ex_res(1, 32'h300);
        chk("t4.redirect_pc", redirect_pc, 32'h300);
        chk("t4.rollback_en_ex", 32'(rollback_en_ex), 1);
        tick();
        chk("t4.corrected_result", 32'(corrected_result), 1);
        tick();

        // 5: mispredict held off by a 3-cycle stall
        fetch(1, 1, 0, 32'h100, 32'h200); tick(); fetch(0, 0, 0, 0, 0); tick();
        PL_stall = 1; ex_res(1, 32'h400);
        for (int i = 0; i < 3; i++) begin
            chk("t5.stalled_rollback", 32'(rollback_en_ex), 0);
            chk("t5.stalled_redirect", 32'(redirect_en), 0);
            tick();
        end
        PL_stall = 0; #1;
        chk("t5.rollback_en_ex", 32'(rollback_en_ex), 1);
        chk("t5.redirect_pc", redirect_pc, 32'h400);
        chk("t5.failed", 32'(prediction_result_branch_failed), 0);
        tick();
        chk("t5.corrected_result", 32'(corrected_result), 1);
        tick();
        chk("t5.single_pulse", 32'(redirect_en), 0);

        // 6: reset during REPAIR
        fetch(1, 1, 1, 32'h100, 32'h200); tick(); fetch(0, 0, 0, 0, 0); tick();
        ex_res(0, 32'h0); tick();
        chk("t6.in_repair", 32'(corrected_en), 1);
        rst_n = 0; #1;
        chk("t6.gated", 32'(corrected_en), 0);
        tick();
        chk("t6.branch_cnt", 32'(branch_cnt), 0);
        chk("t6.mispredict_cnt", 32'(mispredict_cnt), 0);
        rst_n = 1; #1;
        chk("t6.no_repair_pulse", 32'(corrected_en), 0);

        // Saturation: 18 correct not-taken branches, stale targets ignored
        for (int i = 0; i < 18; i++) begin
            fetch(1, 1, 0, 32'h1000 + 32'(i * 4), 32'h5000 + 32'(i));
            ex_res(0, 32'hdead0000 + 32'(i));
            tick();
        end
        fetch(0, 0, 0, 0, 0); tick(); tick(); #1;
        chk("sat.branch_cnt", 32'(branch_cnt), 15);

        // PC wrap on fall-through redirect
        fetch(1, 1, 1, 32'hFFFF_FFFC, 32'h10); tick(); fetch(0, 0, 0, 0, 0); tick();
        ex_res(0, 32'h0);
        chk("wrap.redirect_pc", redirect_pc, 32'h0);
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
